// File: rtl/irq_aggregator_pkg.sv
// rtl/irq_aggregator_pkg.sv - shared constants for the interrupt aggregator
package irq_aggregator_pkg;

  localparam int MAX_IRQ       = 16;
  localparam int VEC_VALID_BIT = 15;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_RAW     = 3'd2;
  localparam logic [2:0] ADDR_VECTOR  = 3'd3;
  localparam logic [2:0] ADDR_EDGE    = 3'd4;
  localparam logic [2:0] ADDR_SWSET   = 3'd5;

  // Bits of a 16-bit register that correspond to real source lines.
  function automatic logic [MAX_IRQ-1:0] src_mask(input int n);
    logic [MAX_IRQ-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_IRQ; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_aggregator_if.sv
// rtl/irq_aggregator_if.sv - 16-bit register-window slave bus
interface irq_aggregator_if;
  import irq_aggregator_pkg::*;

  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output chipselect, address, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, address, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder with valid flag
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [3:0]   index_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    index_o = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        index_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/irq_aggregator.sv
// rtl/irq_aggregator.sv - level/edge interrupt collector with one registered irq line
module irq_aggregator
  import irq_aggregator_pkg::*;
#(
  parameter int          NUM_IRQ      = 8,
  parameter logic [15:0] EDGE_DEFAULT = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  irq_aggregator_if.slave    bus,
  output logic               irq
);

  localparam logic [15:0] SRC_MASK = src_mask(NUM_IRQ);

  logic [15:0] pending_q, pending_d;
  logic [15:0] enable_q;
  logic [15:0] edge_q;
  logic [15:0] irq_in_d_q;
  logic [15:0] readdata_q, readdata_d;
  logic        irq_q;

  logic [15:0] irq_in_ext, set_vec, clr_vec;
  logic        wr_any, wr_pending, wr_enable, wr_edge, wr_swset;
  logic        vec_valid;
  logic [3:0]  vec_index;

  assign irq_in_ext = 16'(irq_in);
  assign wr_any     = bus.chipselect & ~bus.write_n;
  assign wr_pending = wr_any && (bus.address == ADDR_PENDING);
  assign wr_enable  = wr_any && (bus.address == ADDR_ENABLE);
  assign wr_edge    = wr_any && (bus.address == ADDR_EDGE);
  assign wr_swset   = wr_any && (bus.address == ADDR_SWSET);

  // Edge bits: set wins over W1C. Level bits simply track the input.
  // The old edge_q is used so a mode change only takes effect next cycle.
  assign set_vec   = (irq_in_ext & ~irq_in_d_q) | (wr_swset ? bus.writedata : 16'h0000);
  assign clr_vec   = wr_pending ? bus.writedata : 16'h0000;
  assign pending_d = SRC_MASK & ((edge_q & (set_vec | (pending_q & ~clr_vec)))
                                 | (~edge_q & irq_in_ext));

  irq_prio_enc #(.N(NUM_IRQ)) u_prio_enc (
    .req_i   (pending_q[NUM_IRQ-1:0] & enable_q[NUM_IRQ-1:0]),
    .valid_o (vec_valid),
    .index_o (vec_index)
  );

  always_comb begin
    readdata_d = 16'h0000;
    case (bus.address)
      ADDR_PENDING: readdata_d = pending_q;
      ADDR_ENABLE:  readdata_d = enable_q;
      ADDR_RAW:     readdata_d = irq_in_d_q;
      ADDR_VECTOR: begin
        readdata_d[VEC_VALID_BIT] = vec_valid;
        readdata_d[3:0]           = vec_valid ? vec_index : 4'd0;
      end
      ADDR_EDGE:    readdata_d = edge_q;
      default:      readdata_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q  <= 16'h0000;
      enable_q   <= 16'h0000;
      edge_q     <= EDGE_DEFAULT & SRC_MASK;
      irq_in_d_q <= 16'h0000;
      readdata_q <= 16'h0000;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      irq_in_d_q <= irq_in_ext;
      readdata_q <= readdata_d;
      irq_q      <= |(pending_q & enable_q);
      if (wr_enable) enable_q <= bus.writedata & SRC_MASK;
      if (wr_edge)   edge_q   <= bus.writedata & SRC_MASK;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// tb/tb_irq_aggregator.sv - directed self-checking bench for irq_aggregator
module tb_irq_aggregator;
  import irq_aggregator_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irq_in = 8'h00;
  logic       irq;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [15:0] rd;

  irq_aggregator_if bus_if ();

  irq_aggregator #(.NUM_IRQ(8), .EDGE_DEFAULT(16'h0040)) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .bus    (bus_if.slave),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = a;
    bus_if.writedata  = d;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    bus_if.address    = a;
    tick();
    d = bus_if.readdata;
    bus_if.chipselect = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 3'd0;
    bus_if.writedata  = 16'h0000;
    tick(); tick();
    check_eq("reset_irq", {15'h0, irq}, 16'h0000);
    check_eq("reset_readdata", bus_if.readdata, 16'h0000);
    reset = 1'b0;
    tick();

    // Level source 0
    bus_write(ADDR_EDGE, 16'h0000);
    bus_write(ADDR_ENABLE, 16'h0001);
    irq_in[0] = 1'b1;
    bus_if.address = ADDR_PENDING;
    tick();
    check_eq("level_irq_k1", {15'h0, irq}, 16'h0000);
    bus_read(ADDR_PENDING, rd);
    check_eq("level_pending", rd, 16'h0001);
    check_eq("level_irq_k2", {15'h0, irq}, 16'h0001);
    irq_in[0] = 1'b0;
    tick();
    check_eq("level_fall_k1", {15'h0, irq}, 16'h0001);
    tick();
    check_eq("level_fall_k2", {15'h0, irq}, 16'h0000);

    // Edge latch and W1C on source 2
    bus_write(ADDR_EDGE, 16'h0004);
    bus_write(ADDR_ENABLE, 16'h0004);
    irq_in[2] = 1'b1;
    tick();
    irq_in[2] = 1'b0;
    tick(); tick();
    check_eq("edge_irq_held", {15'h0, irq}, 16'h0001);
    bus_read(ADDR_PENDING, rd);
    check_eq("edge_pending", rd, 16'h0004);
    bus_write(ADDR_PENDING, 16'h0004);
    check_eq("w1c_irq_k", {15'h0, irq}, 16'h0001);
    tick();
    check_eq("w1c_irq_k1", {15'h0, irq}, 16'h0000);

    // Set beats clear on source 3
    bus_write(ADDR_EDGE, 16'h000C);
    irq_in[3] = 1'b1;
    bus_write(ADDR_PENDING, 16'h0008);
    bus_read(ADDR_PENDING, rd);
    check_eq("set_beats_clear", rd, 16'h0008);
    irq_in[3] = 1'b0;
    bus_write(ADDR_PENDING, 16'h0008);
    bus_read(ADDR_PENDING, rd);
    check_eq("clear_after", rd, 16'h0000);

    // Priority encoding
    bus_write(ADDR_EDGE, 16'h0022);
    bus_write(ADDR_ENABLE, 16'h00FF);
    irq_in = 8'h22;
    tick();
    irq_in = 8'h00;
    bus_read(ADDR_VECTOR, rd);
    check_eq("vector_1", rd, 16'h8001);
    bus_write(ADDR_PENDING, 16'h0002);
    bus_read(ADDR_VECTOR, rd);
    check_eq("vector_5", rd, 16'h8005);
    bus_write(ADDR_ENABLE, 16'h0000);
    bus_read(ADDR_VECTOR, rd);
    check_eq("vector_none", rd, 16'h0000);
    check_eq("disabled_irq", {15'h0, irq}, 16'h0000);
    bus_write(ADDR_PENDING, 16'h0020);

    // SWSET and masking
    bus_write(ADDR_EDGE, 16'h0010);
    bus_write(ADDR_SWSET, 16'h0010);
    bus_read(ADDR_PENDING, rd);
    check_eq("swset_pending", rd, 16'h0010);
    check_eq("swset_masked_irq", {15'h0, irq}, 16'h0000);
    bus_write(ADDR_ENABLE, 16'h0010);
    check_eq("enable_irq_k", {15'h0, irq}, 16'h0000);
    tick();
    check_eq("enable_irq_k1", {15'h0, irq}, 16'h0001);
    bus_write(ADDR_SWSET, 16'h0001);
    bus_read(ADDR_PENDING, rd);
    check_eq("swset_level_ignored", rd, 16'h0010);
    bus_read(ADDR_SWSET, rd);
    check_eq("swset_reads_zero", rd, 16'h0000);
    bus_write(3'd6, 16'hFFFF);
    bus_read(3'd6, rd);
    check_eq("reserved6", rd, 16'h0000);

    irq_in = 8'hA5;
    tick();
    bus_read(ADDR_RAW, rd);
    check_eq("raw", rd, 16'h00A5);
    irq_in = 8'h00;
    tick();
    bus_read(ADDR_PENDING, rd);
    check_eq("pending_pre_reset", rd, 16'h0010);

    // Asynchronous reset between edges
    bus_if.chipselect = 1'b1;
    bus_if.address    = ADDR_PENDING;
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_irq", {15'h0, irq}, 16'h0000);
    check_eq("async_readdata", bus_if.readdata, 16'h0000);
    bus_if.chipselect = 1'b0;
    tick(); tick();
    reset = 1'b0;
    bus_read(ADDR_PENDING, rd);
    check_eq("post_reset_pending", rd, 16'h0000);
    bus_read(ADDR_ENABLE, rd);
    check_eq("post_reset_enable", rd, 16'h0000);
    bus_read(ADDR_EDGE, rd);
    check_eq("post_reset_edge", rd, 16'h0040);
    bus_read(3'd7, rd);
    check_eq("reserved7", rd, 16'h0000);
    check_eq("post_reset_irq", {15'h0, irq}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
